// File: rtl/unsaved_pio_blinker_pkg.sv
// Shared constants for the PIO blinker: register map, mode encodings and FSM states.
// Optional input synchroniser is enabled with UNSAVED_PIO_BLINKER_SYNC_EN.
package unsaved_pio_blinker_pkg;

    localparam logic [1:0] ADDR_CTRL       = 2'd0;
    localparam logic [1:0] ADDR_PERIOD     = 2'd1;
    localparam logic [1:0] ADDR_STATUS     = 2'd2;
    localparam logic [1:0] ADDR_EDGE_COUNT = 2'd3;

    typedef enum logic [1:0] {
        MODE_FOLLOW  = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FOLLOW    = 3'd1,
        ST_BLINK_ON  = 3'd2,
        ST_BLINK_OFF = 3'd3,
        ST_PULSE     = 3'd4
    } state_e;

    // Counter load value: a period of 0 is treated as 1, so the load is never negative.
    function automatic logic [31:0] load_value(input logic [31:0] period);
        return (period == 32'd0) ? 32'd0 : period - 32'd1;
    endfunction

endpackage

// File: rtl/unsaved_pio_edge_sync.sv
// Input stage for the PIO level: optional 2-flop synchroniser, pio_q/pio_qq flops, rise detect.
// UNSAVED_PIO_BLINKER_SYNC_EN inserts the synchroniser ahead of pio_q.
module unsaved_pio_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic pio_in,
    output logic pio_q,
    output logic rise
);

    logic stage_in;
    logic pio_qq;

`ifdef UNSAVED_PIO_BLINKER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pio_in};
        end
    end

    assign stage_in = sync_q[1];
`else
    assign stage_in = pio_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pio_q  <= 1'b0;
            pio_qq <= 1'b0;
        end else begin
            pio_q  <= stage_in;
            pio_qq <= pio_q;
        end
    end

    assign rise = pio_q & ~pio_qq;

endmodule

// File: rtl/unsaved_pio_blinker.sv
// LED/strobe driver behind a 1-bit PIO: follow, blink-while-high or one-shot pulse per rising edge.
// Avalon-MM slave holds CONTROL, PERIOD, STATUS, EDGE_COUNT; UNSAVED_PIO_BLINKER_SYNC_EN adds an input synchroniser.
module unsaved_pio_blinker #(
    parameter logic [31:0] PERIOD_RESET = 32'd50_000_000,
    parameter logic [1:0]  MODE_RESET   = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pio_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        led_out
);
    import unsaved_pio_blinker_pkg::*;

    logic        pio_q;
    logic        rise;
    logic [1:0]  mode_q;
    logic [31:0] period_q;
    logic [31:0] edge_count;
    logic [31:0] cnt;
    state_e      state;

    // Bus handshake: a write is accepted in the cycle chipselect && !write_n (no wait states);
    // readdata is a pure function of address and current register state.
    logic wr, ctrl_wr, mode_change, is_follow, is_blink, is_oneshot, busy;
    logic [31:0] load;

    assign wr          = chipselect & ~write_n;
    assign ctrl_wr     = wr && (address == ADDR_CTRL);
    assign mode_change = ctrl_wr && (writedata[1:0] != mode_q);
    assign is_follow   = (mode_q == MODE_FOLLOW) || (mode_q == MODE_RSVD);
    assign is_blink    = (mode_q == MODE_BLINK);
    assign is_oneshot  = (mode_q == MODE_ONESHOT);
    assign busy        = (state != ST_IDLE);
    assign load        = load_value(period_q);

    unsaved_pio_edge_sync u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .pio_in (pio_in),
        .pio_q  (pio_q),
        .rise   (rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_RESET;
            period_q   <= PERIOD_RESET;
            edge_count <= 32'd0;
        end else begin
            if (ctrl_wr) begin
                mode_q <= writedata[1:0];
            end
            if (wr && (address == ADDR_PERIOD)) begin
                period_q <= writedata;
            end
            // A clear write beats a coincident rising edge.
            if (wr && (address == ADDR_EDGE_COUNT)) begin
                edge_count <= 32'd0;
            end else if (rise && (edge_count != 32'hFFFF_FFFF)) begin
                edge_count <= edge_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 32'd0;
            led_out <= 1'b0;
        end else if (mode_change) begin
            state   <= ST_IDLE;
            cnt     <= 32'd0;
            led_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    led_out <= 1'b0;
                    if (is_follow) begin
                        state <= ST_FOLLOW;
                    end else if (is_blink && pio_q) begin
                        state   <= ST_BLINK_ON;
                        led_out <= 1'b1;
                        cnt     <= load;
                    end else if (is_oneshot && rise) begin
                        state   <= ST_PULSE;
                        led_out <= 1'b1;
                        cnt     <= load;
                    end
                end
                ST_FOLLOW: begin
                    led_out <= pio_q;
                end
                ST_BLINK_ON: begin
                    if (!pio_q) begin
                        state   <= ST_IDLE;
                        led_out <= 1'b0;
                    end else if (cnt == 32'd0) begin
                        state   <= ST_BLINK_OFF;
                        led_out <= 1'b0;
                        cnt     <= load;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                ST_BLINK_OFF: begin
                    if (!pio_q) begin
                        state   <= ST_IDLE;
                        led_out <= 1'b0;
                    end else if (cnt == 32'd0) begin
                        state   <= ST_BLINK_ON;
                        led_out <= 1'b1;
                        cnt     <= load;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                ST_PULSE: begin
                    // Edges seen here are only counted; the pulse is not retriggered.
                    if (cnt == 32'd0) begin
                        state   <= ST_IDLE;
                        led_out <= 1'b0;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    led_out <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_CTRL:       readdata = {30'd0, mode_q};
            ADDR_PERIOD:     readdata = period_q;
            ADDR_STATUS:     readdata = {29'd0, pio_q, busy, led_out};
            ADDR_EDGE_COUNT: readdata = edge_count;
            default:         readdata = 32'd0;
        endcase
    end

endmodule
